// File: rtl/player_input_sched.sv
// Per-player keyboard scheduler: samples each player's key once per frame and
// applies lane/speed actions with press, hold-delay and auto-repeat behaviour.
module player_input_sched #(
    parameter int NUM_LANES    = 2,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       game_active,
    input  logic [7:0] player1_key,
    input  logic [7:0] player2_key,
    output logic [1:0] p1_lane,
    output logic [1:0] p2_lane,
    output logic [2:0] p1_speed,
    output logic [2:0] p2_speed,
    output logic       p1_move,
    output logic       p2_move
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [2:0] ACT_NONE  = 3'd0;
    localparam logic [2:0] ACT_LEFT  = 3'd1;
    localparam logic [2:0] ACT_RIGHT = 3'd2;
    localparam logic [2:0] ACT_UP    = 3'd3;
    localparam logic [2:0] ACT_DOWN  = 3'd4;

    localparam logic [1:0] LANE_MAX   = 2'(NUM_LANES - 1);
    localparam logic [7:0] DELAY_LOAD = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RATE_LOAD  = 8'(REPEAT_RATE - 1);

    // Resetting to 1 suppresses a spurious tick when frame_clk is already high.
    logic frame_clk_d_q;
    logic frame_tick;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_d_q <= 1'b1;
        end else begin
            frame_clk_d_q <= frame_clk;
        end
    end

    assign frame_tick = frame_clk & ~frame_clk_d_q;

    logic [15:0] keys_w;
    logic [3:0]  lane_w;
    logic [5:0]  speed_w;
    logic [1:0]  move_w;

    assign keys_w = {player2_key, player1_key};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            localparam logic [7:0] K_LEFT  = (gi == 0) ? 8'h04 : 8'h5C;
            localparam logic [7:0] K_RIGHT = (gi == 0) ? 8'h07 : 8'h5E;
            localparam logic [7:0] K_UP    = (gi == 0) ? 8'h1A : 8'h60;
            localparam logic [7:0] K_DOWN  = (gi == 0) ? 8'h16 : 8'h5D;

            logic [7:0] key;
            logic [2:0] act;
            logic       apply;

            logic [1:0] state_q, state_d;
            logic [7:0] cnt_q, cnt_d;
            logic [7:0] last_key_q, last_key_d;
            logic [1:0] lane_q, lane_d;
            logic [2:0] speed_q, speed_d;
            logic       move_q, move_d;

            assign key = keys_w[gi*8 +: 8];

            always_comb begin
                act = ACT_NONE;
                if (key == K_LEFT)       act = ACT_LEFT;
                else if (key == K_RIGHT) act = ACT_RIGHT;
                else if (key == K_UP)    act = ACT_UP;
                else if (key == K_DOWN)  act = ACT_DOWN;
            end

            always_comb begin
                state_d    = state_q;
                cnt_d      = cnt_q;
                last_key_d = last_key_q;
                lane_d     = lane_q;
                speed_d    = speed_q;
                apply      = 1'b0;

                if (!game_active) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (frame_tick) begin
                    if (act == ACT_NONE) begin
                        state_d = ST_IDLE;
                    end else if (state_q == ST_IDLE || key != last_key_q) begin
                        // A new or different key restarts the hold delay.
                        apply      = 1'b1;
                        last_key_d = key;
                        cnt_d      = DELAY_LOAD;
                        state_d    = ST_HELD;
                    end else if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        apply   = 1'b1;
                        cnt_d   = RATE_LOAD;
                        state_d = ST_REPEAT;
                    end
                end

                if (apply) begin
                    case (act)
                        ACT_LEFT:  if (lane_q != 2'd0)    lane_d  = lane_q - 2'd1;
                        ACT_RIGHT: if (lane_q < LANE_MAX) lane_d  = lane_q + 2'd1;
                        ACT_UP:    if (speed_q != 3'd7)   speed_d = speed_q + 3'd1;
                        ACT_DOWN:  if (speed_q != 3'd0)   speed_d = speed_q - 3'd1;
                        default:   ;
                    endcase
                end

                move_d = (lane_d != lane_q);
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= 8'd0;
                    last_key_q <= 8'h00;
                    lane_q     <= 2'd0;
                    speed_q    <= 3'd0;
                    move_q     <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    cnt_q      <= cnt_d;
                    last_key_q <= last_key_d;
                    lane_q     <= lane_d;
                    speed_q    <= speed_d;
                    move_q     <= move_d;
                end
            end

            assign lane_w[gi*2 +: 2]  = lane_q;
            assign speed_w[gi*3 +: 3] = speed_q;
            assign move_w[gi]         = move_q;
        end
    endgenerate

    assign p1_lane  = lane_w[1:0];
    assign p2_lane  = lane_w[3:2];
    assign p1_speed = speed_w[2:0];
    assign p2_speed = speed_w[5:3];
    assign p1_move  = move_w[0];
    assign p2_move  = move_w[1];

endmodule

// File: doc/player_input_sched.md
# player_input_sched

Per-player input scheduler for the two-car game. It sits between the keycode splitter, which delivers one 8-bit USB keycode per player (0x00 = no key), and the car/ball logic. Once per video frame it samples each player's key and applies the key to that player's lane index and speed level. Each player has its own press/hold/auto-repeat FSM, so both players are served in the same frame with no interference.

## Interface
- `NUM_LANES`, default 2: lanes per car, legal range 2..4.
- `REPEAT_DELAY`, default 20: frames a key must be held before the first auto-repeat, legal range 1..255.
- `REPEAT_RATE`, default 6: frames between later auto-repeats, legal range 1..255.

Ports:
- `Clk`  in  1  system clock. This is the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `frame_clk`  in  1  vsync-derived frame signal, synchronous to `Clk`. The rising edge marks a frame.
- `game_active`  in  1  when 0, inputs are ignored and both FSMs are forced to IDLE.
- `player1_key`  in  8  player 1 keycode: 0x04 a, 0x07 d, 0x1A w, 0x16 s, 0x00 none.
- `player2_key`  in  8  player 2 keycode: 0x5C 4, 0x5E 6, 0x60 8, 0x5D 5, 0x00 none.
- `p1_lane`, `p2_lane`  out  2  current lane index, 0..NUM_LANES-1.
- `p1_speed`, `p2_speed`  out  3  speed level, 0..7.
- `p1_move`, `p2_move`  out  1  one-cycle strobe, high when the lane index actually changed.

## Operation
- **Frame tick.** `frame_tick = frame_clk & ~frame_clk_d`, where `frame_clk_d` is `frame_clk` registered on `Clk`. `frame_clk_d` resets to 1, so no tick fires on the first cycle after reset.
- **Key decode per player.**
  - LEFT: a or 4.
  - RIGHT: d or 6.
  - UP: w or 8.
  - DOWN: s or 5.
  - Any other value, including the other player's keys, counts as NONE.
- **Actions.** All arithmetic saturates:
  - LEFT: lane − 1, floor 0.
  - RIGHT: lane + 1, ceiling NUM_LANES−1.
  - UP: speed + 1, ceiling 7.
  - DOWN: speed − 1, floor 0.
- **FSM.** Each player has an FSM with states IDLE, HELD and REPEAT, a registered `last_key`, and an 8-bit frame counter `cnt`. States change only on `frame_tick`.
  - IDLE, key is NONE: stay in IDLE.
  - IDLE, valid key: apply the action, set `last_key`=key, `cnt`=REPEAT_DELAY−1, go to HELD.
  - HELD or REPEAT, key is NONE: go to IDLE.
  - HELD or REPEAT, valid key ≠ `last_key`: treat as a new press. Apply the action, update `last_key`, set `cnt`=REPEAT_DELAY−1, go to HELD.
  - HELD or REPEAT, key = `last_key` and `cnt`≠0: decrement `cnt` and stay in the same state.
  - HELD or REPEAT, key = `last_key` and `cnt`=0: apply the action, set `cnt`=REPEAT_RATE−1, go to REPEAT.
- **Move strobe.** `pN_move` pulses only when the lane value changes. It does not pulse on a saturated LEFT/RIGHT or on any UP/DOWN.
- **game_active=0.** Both FSMs go to IDLE and `cnt` is cleared at the next `Clk` edge. Lane and speed hold their values and no strobes are issued. On re-enable, a key that is still held counts as a fresh press on the next tick.
- **Independence.** The two players share no state. Simultaneous events on the same tick are all applied.
- **Reset.** Reset is asynchronous and may be asserted at any point, including mid-hold. It forces:
  - lanes = 0 and speeds = 0;
  - move strobes = 0;
  - both FSMs to IDLE, with `cnt` = 0 and `last_key` = 0x00;
  - `frame_clk_d` = 1.

## Timing
- Latency: a `frame_tick` seen in cycle N updates lane, speed and the strobe at the clock edge that ends cycle N. The strobe is high for exactly cycle N+1.
- Key inputs matter only in the tick cycle. Changes between ticks are invisible.
- Auto-repeat cadence for a continuously held key:
  - first action at tick 0;
  - second action at tick REPEAT_DELAY;
  - after that, every REPEAT_RATE ticks.
- If `frame_clk` stays high for multiple cycles, only one tick is produced.

## Test plan
- **Reset.** Assert `Reset` mid-run → all outputs go to 0 immediately without waiting for a clock edge. After release, hold `frame_clk`=1 → no tick and no strobe.
- **Single tap.** p1 presses d (0x07) for one tick with NUM_LANES=2 → `p1_lane` 0→1 and `p1_move` high for one cycle. A second d tap → lane stays 1 and no strobe.
- **Auto-repeat.** Set REPEAT_DELAY=3, REPEAT_RATE=2. Hold 8 (0x60) for 10 ticks → `p2_speed` increments on ticks 0, 3, 5, 7, 9, giving a final value of 5.
- **Key change mid-hold.** Hold a (0x04) for 2 ticks, then d (0x07) → d is applied immediately as a new press and the delay counter restarts.
- **Simultaneous players.** On the same tick, p1=0x07 and p2=0x5C with p2_lane=1 → `p1_lane`=1 and `p2_lane`=0, with both strobes high in the same cycle.
- **Gating.** Hold 0x1A, drop `game_active` for 5 ticks, then restore it → speed is frozen while gated. On the first tick after re-enable the speed increments once and the FSM is in HELD.
